imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, number of 32-bit words in the instruction memory.
REQ-002 Ports (clock and reset first):
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle load request.
- rx_data  in  8  incoming program byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction-memory write strobe.
- mem_waddr  out  32  byte address of the write, word aligned.
- mem_wdata  out  32  write data word.
- cpu_hold  out  1  holds the processor PC/fetch in reset.
- load_done  out  1  program loaded successfully.
- load_err  out  1  header rejected.
- words_loaded  out  16  count of words written in the current load.

Function
REQ-003 SHALL be a state machine with states IDLE, HDR, DATA, DONE and ERR.
REQ-004 A byte SHALL transfer only on a clk edge where rx_valid=1 and rx_ready=1.
REQ-005 rx_ready SHALL be 1 in HDR and DATA and 0 in all other states.
REQ-006 IDLE: cpu_hold=1; start=1 SHALL move to HDR.
REQ-007 HDR: SHALL accept 2 bytes, little-endian, forming word count N[15:0].
REQ-008 After the 2nd header byte, SHALL go to ERR if N=0 or N>DEPTH_WORDS, else to DATA.
REQ-009 DATA: SHALL assemble each 4 accepted bytes little-endian (first byte -> bits 7:0) into one word.
REQ-010 The cycle after the 4th byte of word k is accepted, SHALL assert mem_we for exactly 1 cycle with mem_waddr=4*k, mem_wdata=the word, k counting from 0.
REQ-011 rx_ready SHALL stay 1 during that write cycle; byte acceptance SHALL not stall.
REQ-012 words_loaded SHALL increment in the same cycle as each mem_we.
REQ-013 After the write of word N-1, SHALL enter DONE.
REQ-014 DONE: cpu_hold=0, load_done=1; start=1 SHALL begin a new load in HDR with cpu_hold=1.
REQ-015 ERR: load_err=1, cpu_hold=1, mem_we=0; start=1 SHALL move to HDR and clear load_err.
REQ-016 start=1 in HDR or DATA SHALL abort the load, discard any partial word, clear words_loaded and restart in HDR; a byte accepted in that same cycle SHALL be discarded.
REQ-017 mem_waddr[1:0] SHALL always be 0; bits above log2(DEPTH_WORDS)+1 SHALL be 0.
REQ-018 mem_we SHALL never assert outside DATA and the cycle immediately following it.
REQ-019 rx_valid with rx_ready=0 SHALL be ignored; no byte is buffered.

Reset
REQ-020 rst=1 SHALL, on the next edge from any state, force IDLE and set cpu_hold=1, rx_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, load_done=0, load_err=0, words_loaded=0.
REQ-021 Reset mid-load SHALL discard the partial word and header; no write SHALL issue in the cycle after reset.
REQ-022 rst SHALL have priority over start and rx_valid.

Structure
REQ-023 The state encoding and header byte count (2) and the bytes-per-word constant (4) SHALL live in the shared processor package.
REQ-024 The byte-to-word assembler (shift register and byte counter) SHALL be one sub-module, imem_word_packer; the FSM and write sequencing stay in imem_loader.

Verification
REQ-025 After reset, start, then bytes 03 00, 93 00 10 00, 13 01 20 00, b3 81 20 00 -> three writes: 0x0:0x00100093, 0x4:0x00200113, 0x8:0x002081b3; load_done=1, cpu_hold=0, words_loaded=3.
REQ-026 Header 00 00 -> ERR, load_err=1, no mem_we; header 41 00 with DEPTH_WORDS=64 -> ERR.
REQ-027 With rx_valid toggled every other cycle across a 2-word load -> the same two words are written; mem_we is high exactly 2 cycles.
REQ-028 rst asserted after 2 bytes of word 1 -> IDLE, all outputs at reset values; a fresh load then writes word 0 to address 0x0.
REQ-029 start asserted mid-word -> restart in HDR; the new header and data produce writes from address 0x0 and no partial word is written.
REQ-030 A 64-word load -> last write at mem_waddr=0xFC; load_done=1 one cycle later.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants and types for the instruction-memory loader.
// Holds the FSM encoding and the framing constants of the byte stream.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } ld_state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = byte source / memory side.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler: the first byte lands in bits 7:0.
// word_vld_o flags the byte that completes a word, with word_o valid alongside.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic                        byte_vld_i,
  input  logic [7:0]                  byte_i,
  output logic                        word_vld_o,
  output logic [8*BYTES_PER_WORD-1:0] word_o
);
  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam int SH_W  = 8 * (BYTES_PER_WORD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [SH_W-1:0]  shreg_q;

  assign word_vld_o = byte_vld_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
  assign word_o     = {byte_i, shreg_q};

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (byte_vld_i) begin
      cnt_q <= word_vld_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Older bytes shift toward bit 0 so the oldest ends up lowest.
  always_ff @(posedge clk) begin
    if (byte_vld_i) begin
      shreg_q <= {byte_i, shreg_q[SH_W-1:8]};
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream and writes it into
// instruction memory while holding the CPU, releasing it once loading completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_loader_if.master       bus,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_err,
  output logic [15:0]         words_loaded
);
  localparam logic [15:0] DEPTH_N = 16'(DEPTH_WORDS);

  ld_state_e   state_q;
  logic        rx_ready_q;
  logic        mem_we_q;
  logic [31:0] mem_waddr_q;
  logic [31:0] mem_wdata_q;
  logic        cpu_hold_q;
  logic        load_done_q;
  logic        load_err_q;
  logic [15:0] words_q;
  logic        hdr_cnt_q;
  logic [7:0]  hdr_lo_q;
  logic [15:0] n_q;
  logic        last_q;

  logic        acc;
  logic [15:0] n_d;
  logic        hdr_bad;
  logic        pk_vld;
  logic        pk_clr;
  logic        pk_word_vld;
  logic [31:0] pk_word;

  assign acc     = bus.rx_valid && rx_ready_q;
  assign n_d     = {bus.rx_data, hdr_lo_q};
  assign hdr_bad = (n_d == 16'd0) || (n_d > DEPTH_N);
  // Once all N words are assembled, bytes during the final write cycle are dropped.
  assign pk_vld  = acc && (state_q == ST_DATA) && !last_q && !start;
  assign pk_clr  = start || (state_q != ST_DATA);

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (pk_clr),
    .byte_vld_i (pk_vld),
    .byte_i     (bus.rx_data),
    .word_vld_o (pk_word_vld),
    .word_o     (pk_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      words_q     <= '0;
      hdr_cnt_q   <= 1'b0;
      hdr_lo_q    <= '0;
      n_q         <= '0;
      last_q      <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (start) begin
        // Start from any state (re)opens a load; a byte seen this cycle is discarded.
        state_q     <= ST_HDR;
        rx_ready_q  <= 1'b1;
        cpu_hold_q  <= 1'b1;
        load_done_q <= 1'b0;
        load_err_q  <= 1'b0;
        words_q     <= '0;
        hdr_cnt_q   <= 1'b0;
        last_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_HDR: begin
            if (acc) begin
              if (hdr_cnt_q != 1'(HDR_BYTES - 1)) begin
                hdr_lo_q  <= bus.rx_data;
                hdr_cnt_q <= 1'b1;
              end else begin
                hdr_cnt_q <= 1'b0;
                n_q       <= n_d;
                if (hdr_bad) begin
                  state_q    <= ST_ERR;
                  rx_ready_q <= 1'b0;
                  load_err_q <= 1'b1;
                end else begin
                  state_q <= ST_DATA;
                end
              end
            end
          end
          ST_DATA: begin
            if (last_q) begin
              state_q     <= ST_DONE;
              rx_ready_q  <= 1'b0;
              cpu_hold_q  <= 1'b0;
              load_done_q <= 1'b1;
              last_q      <= 1'b0;
            end else if (pk_word_vld) begin
              mem_we_q    <= 1'b1;
              mem_waddr_q <= 32'({words_q, 2'b00});
              mem_wdata_q <= pk_word;
              words_q     <= words_q + 16'd1;
              last_q      <= (words_q + 16'd1) == n_q;
            end
          end
          ST_IDLE, ST_DONE, ST_ERR: ;
          default: begin
            state_q    <= ST_IDLE;
            rx_ready_q <= 1'b0;
            cpu_hold_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign load_done     = load_done_q;
  assign load_err      = load_err_q;
  assign words_loaded  = words_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of complete loads plus hand-written
// sequences for flow control, reset, abort and a full-depth load.
module tb_imem_loader;
  logic        clk;
  logic        rst;
  logic        start;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  imem_loader_if bus ();

  imem_loader #(.DEPTH_WORDS(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Write log captured away from the active edge.
  logic [31:0] wa [0:255];
  logic [31:0] wd [0:255];
  logic [15:0] wl [0:255];
  int          wn = 0;

  always @(negedge clk) begin
    if (bus.mem_we && wn < 256) begin
      wa[wn] = bus.mem_waddr;
      wd[wn] = bus.mem_wdata;
      wl[wn] = words_loaded;
      wn = wn + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rx_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=rx_ready_low required=rx_ready_high");
    end
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] v;
    v = w;
    send(v[7:0]);
    send(v[15:8]);
    send(v[23:16]);
    send(v[31:24]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    logic [7:0]        h0;
    logic [7:0]        h1;
    int                nw;
    logic [3:0][31:0]  w;
    logic              err;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int base;
    logic [31:0] ew;

    start        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_waddr", bus.mem_waddr, 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);

    tbl[0] = '{h0: 8'h03, h1: 8'h00, nw: 3,
               w: {32'h0, 32'h002081b3, 32'h00200113, 32'h00100093}, err: 1'b0};
    tbl[1] = '{h0: 8'h00, h1: 8'h00, nw: 0, w: '0, err: 1'b1};
    tbl[2] = '{h0: 8'h41, h1: 8'h00, nw: 0, w: '0, err: 1'b1};
    tbl[3] = '{h0: 8'h01, h1: 8'h00, nw: 1,
               w: {32'h0, 32'h0, 32'h0, 32'hdeadbeef}, err: 1'b0};
    tbl[4] = '{h0: 8'h02, h1: 8'h00, nw: 2,
               w: {32'h0, 32'h0, 32'hcafef00d, 32'h12345678}, err: 1'b0};

    for (int v = 0; v < 5; v++) begin
      base = wn;
      pulse_start();
      chk($sformatf("v%0d_hdr_ready", v), 32'(bus.rx_ready), 32'd1);
      send(tbl[v].h0);
      send(tbl[v].h1);
      if (!tbl[v].err)
        for (int i = 0; i < tbl[v].nw; i++) send_word(tbl[v].w[i]);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_err", v), 32'(load_err), 32'(tbl[v].err));
      chk($sformatf("v%0d_done", v), 32'(load_done), 32'(!tbl[v].err));
      chk($sformatf("v%0d_hold", v), 32'(cpu_hold), 32'(tbl[v].err));
      chk($sformatf("v%0d_ready", v), 32'(bus.rx_ready), 32'd0);
      chk($sformatf("v%0d_words", v), 32'(words_loaded), 32'(tbl[v].nw));
      chk($sformatf("v%0d_nwrites", v), 32'(wn - base), 32'(tbl[v].nw));
      for (int i = 0; i < tbl[v].nw; i++) begin
        chk($sformatf("v%0d_addr%0d", v, i), wa[base+i], 32'(4 * i));
        chk($sformatf("v%0d_data%0d", v, i), wd[base+i], tbl[v].w[i]);
        chk($sformatf("v%0d_wl%0d", v, i), 32'(wl[base+i]), 32'(i + 1));
      end
    end

    // Byte source idles every other cycle across a 2-word load.
    base = wn;
    pulse_start();
    send(8'h02);
    @(posedge clk);
    send(8'h00);
    for (int i = 0; i < 2; i++) begin
      ew = (i == 0) ? 32'h00100093 : 32'h00200113;
      for (int j = 0; j < 4; j++) begin
        @(posedge clk);
        send(ew[8*j +: 8]);
      end
    end
    repeat (3) @(negedge clk);
    chk("gap_nwrites", 32'(wn - base), 32'd2);
    chk("gap_data0", wd[base], 32'h00100093);
    chk("gap_data1", wd[base+1], 32'h00200113);
    chk("gap_addr1", wa[base+1], 32'h4);
    chk("gap_done", 32'(load_done), 32'd1);

    // Reset after two bytes of word 1.
    pulse_start();
    send(8'h02);
    send(8'h00);
    send_word(32'h01020304);
    send(8'haa);
    send(8'hbb);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = wn;
    chk("mrst_hold", 32'(cpu_hold), 32'd1);
    chk("mrst_ready", 32'(bus.rx_ready), 32'd0);
    chk("mrst_we", 32'(bus.mem_we), 32'd0);
    chk("mrst_waddr", bus.mem_waddr, 32'h0);
    chk("mrst_wdata", bus.mem_wdata, 32'h0);
    chk("mrst_words", 32'(words_loaded), 32'd0);
    chk("mrst_done", 32'(load_done), 32'd0);
    repeat (2) @(negedge clk);
    chk("mrst_nowrite", 32'(wn - base), 32'd0);
    pulse_start();
    send(8'h01);
    send(8'h00);
    send_word(32'ha5a50001);
    repeat (3) @(negedge clk);
    chk("mrst_new_n", 32'(wn - base), 32'd1);
    chk("mrst_new_addr", wa[base], 32'h0);
    chk("mrst_new_data", wd[base], 32'ha5a50001);

    // Start mid-word, with a byte presented in the same cycle.
    pulse_start();
    send(8'h02);
    send(8'h00);
    send_word(32'h55667788);
    send(8'h99);
    send(8'h88);
    @(negedge clk);
    start        = 1'b1;
    bus.rx_data  = 8'hff;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    base = wn;
    @(negedge clk);
    chk("abort_words", 32'(words_loaded), 32'd0);
    chk("abort_ready", 32'(bus.rx_ready), 32'd1);
    chk("abort_hold", 32'(cpu_hold), 32'd1);
    send(8'h01);
    send(8'h00);
    send_word(32'h11223344);
    repeat (3) @(negedge clk);
    chk("abort_err", 32'(load_err), 32'd0);
    chk("abort_nwrites", 32'(wn - base), 32'd1);
    chk("abort_addr", wa[base], 32'h0);
    chk("abort_data", wd[base], 32'h11223344);

    // Full-depth load.
    base = wn;
    pulse_start();
    send(8'h40);
    send(8'h00);
    for (int k = 0; k < 64; k++) send_word({8'(k), 8'(~k), 8'h5a, 8'(k + 1)});
    @(negedge clk);
    chk("full_last_we", 32'(bus.mem_we), 32'd1);
    chk("full_last_addr", bus.mem_waddr, 32'hfc);
    chk("full_last_data", bus.mem_wdata, {8'd63, 8'(~63), 8'h5a, 8'd64});
    chk("full_done_early", 32'(load_done), 32'd0);
    @(negedge clk);
    chk("full_done", 32'(load_done), 32'd1);
    chk("full_we_off", 32'(bus.mem_we), 32'd0);
    chk("full_words", 32'(words_loaded), 32'd64);
    chk("full_nwrites", 32'(wn - base), 32'd64);
    chk("full_addr17", wa[base+17], 32'h44);
    chk("full_data17", wd[base+17], {8'd17, 8'(~17), 8'h5a, 8'd18});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
